// File: rtl/drawing_pkg.sv
// Shared definitions for the drawing controller and the drawing datapath.
// Contents: FSM state codes, default screen and cell geometry, reserved colours, colour stepping.
// No ports; imported with import drawing_pkg::*.
package drawing_pkg;

  localparam int SCREEN_WIDTH_DEF   = 640;
  localparam int SCREEN_HEIGHT_DEF  = 480;
  localparam int CELL_DIMENSION_DEF = 5;

  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] BORDER = 3'b110;
  localparam logic [2:0] GRID   = 3'b000;

  // Encoding is shared with the datapath; do not renumber.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAN = 3'd3,
    ST_DRAW  = 3'd4,
    ST_ERASE = 3'd5,
    ST_CLEAR = 3'd6
  } state_t;

  // Pen colour walks 001..111 and wraps to 001, so the grid colour (000) is never produced.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == WHITE) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/drawing_control_if.sv
// Bundle between the drawing controller and its user/datapath.
// Inputs: step pulses, command pulses, colour pulse, iDone/iMove from the datapath.
// Outputs: cursor cell, state code, pen colour, busy flag.
interface drawing_control_if #(
  parameter int UPPER_BITS = 7
);
  logic                  iUp;
  logic                  iDown;
  logic                  iLeft;
  logic                  iRight;
  logic                  iDraw;
  logic                  iErase;
  logic                  iClear;
  logic                  iColourCycle;
  logic                  iDone;
  logic                  iMove;
  logic [UPPER_BITS-1:0] oX_cell;
  logic [UPPER_BITS-1:0] oY_cell;
  logic [2:0]            oState;
  logic [2:0]            oColour;
  logic                  oBusy;

  // master: stimulus / datapath side
  modport master (
    output iUp, iDown, iLeft, iRight, iDraw, iErase, iClear, iColourCycle, iDone, iMove,
    input  oX_cell, oY_cell, oState, oColour, oBusy
  );

  // slave: the controller
  modport slave (
    input  iUp, iDown, iLeft, iRight, iDraw, iErase, iClear, iColourCycle, iDone, iMove,
    output oX_cell, oY_cell, oState, oColour, oBusy
  );
endinterface

// File: rtl/cursor_position.sv
// Cursor cell registers with clamped single-cell steps and a one-deep pending step register.
// Ports: iClk/iResetn, four step pulses, step_en (apply now), x_cell/y_cell outputs.
// Pulses arriving while step_en=0 are OR-merged into pending and applied on the next step_en cycle.
module cursor_position
  import drawing_pkg::*;
#(
  parameter int GRID_W     = 128,
  parameter int GRID_H     = 96,
  parameter int UPPER_BITS = 7
) (
  input  logic                  iClk,
  input  logic                  iResetn,
  input  logic                  iUp,
  input  logic                  iDown,
  input  logic                  iLeft,
  input  logic                  iRight,
  input  logic                  step_en,
  output logic [UPPER_BITS-1:0] x_cell,
  output logic [UPPER_BITS-1:0] y_cell
);

  localparam logic [UPPER_BITS-1:0] X_MAX = UPPER_BITS'(GRID_W - 1);
  localparam logic [UPPER_BITS-1:0] Y_MAX = UPPER_BITS'(GRID_H - 1);

  // Bit order {up, down, left, right}
  logic [3:0]            pending;
  logic [3:0]            eff;
  logic [UPPER_BITS-1:0] x_step;
  logic [UPPER_BITS-1:0] y_step;

  // Current pulses are folded in so a step applied this cycle is never lost.
  assign eff = pending | {iUp, iDown, iLeft, iRight};

  // Opposing directions cancel; a step off the grid edge leaves the coordinate unchanged.
  always_comb begin
    x_step = x_cell;
    y_step = y_cell;
    if (eff[1] && !eff[0] && (x_cell != '0)) begin
      x_step = x_cell - 1'b1;
    end else if (eff[0] && !eff[1] && (x_cell != X_MAX)) begin
      x_step = x_cell + 1'b1;
    end
    if (eff[3] && !eff[2] && (y_cell != '0)) begin
      y_step = y_cell - 1'b1;
    end else if (eff[2] && !eff[3] && (y_cell != Y_MAX)) begin
      y_step = y_cell + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      x_cell  <= '0;
      y_cell  <= '0;
      pending <= '0;
    end else if (step_en) begin
      x_cell  <= x_step;
      y_cell  <= y_step;
      pending <= '0;
    end else begin
      pending <= eff;
    end
  end

endmodule

// File: rtl/drawing_control.sv
// Drawing controller: sequences the datapath through move/clean/draw/erase/clear and owns the pen colour.
// Ports: iClk, iResetn, bus (slave side of drawing_control_if).
// Commands are only accepted in IDLE; cursor steps outside IDLE are deferred, never dropped.
module drawing_control
  import drawing_pkg::*;
#(
  parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF,
  parameter int CELL_DIMENSION = CELL_DIMENSION_DEF,
  parameter int UPPER_BITS     = $clog2(((SCREEN_WIDTH / CELL_DIMENSION) > (SCREEN_HEIGHT / CELL_DIMENSION)) ?
                                        (SCREEN_WIDTH / CELL_DIMENSION) : (SCREEN_HEIGHT / CELL_DIMENSION))
) (
  input logic              iClk,
  input logic              iResetn,
  drawing_control_if.slave bus
);

  localparam int GRID_W = SCREEN_WIDTH / CELL_DIMENSION;
  localparam int GRID_H = SCREEN_HEIGHT / CELL_DIMENSION;

  state_t     state;
  state_t     state_n;
  logic       step_apply;
  logic [2:0] colour;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Steps are applied only in an IDLE cycle with nothing else happening, which keeps the
  // cell frozen through MOVE/WAIT/CLEAN and through any command just accepted.
  always_comb begin
    state_n    = state;
    step_apply = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.iMove) begin
          state_n = ST_MOVE;
        end else if (bus.iClear) begin
          state_n = ST_CLEAR;
        end else if (bus.iErase) begin
          state_n = ST_ERASE;
        end else if (bus.iDraw) begin
          state_n = ST_DRAW;
        end else begin
          step_apply = 1'b1;
        end
      end
      ST_MOVE:  if (bus.iDone) state_n = ST_WAIT;
      ST_WAIT:  state_n = ST_CLEAN;
      ST_CLEAN,
      ST_DRAW,
      ST_ERASE,
      ST_CLEAR: if (bus.iDone) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      colour <= WHITE;
    end else if (bus.iColourCycle) begin
      colour <= next_colour(colour);
    end
  end

  cursor_position #(
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .UPPER_BITS (UPPER_BITS)
  ) u_cursor (
    .iClk    (iClk),
    .iResetn (iResetn),
    .iUp     (bus.iUp),
    .iDown   (bus.iDown),
    .iLeft   (bus.iLeft),
    .iRight  (bus.iRight),
    .step_en (step_apply),
    .x_cell  (bus.oX_cell),
    .y_cell  (bus.oY_cell)
  );

  assign bus.oState  = state;
  assign bus.oColour = colour;
  assign bus.oBusy   = (state != ST_IDLE);

endmodule
